// File: rtl/serial_demux_1to8.sv
// serial_demux_1to8
//   Assembles an LSB-first serial bit stream into 8-bit words. It is the
//   inverse of an 8:1 select: frame bit k lands on O[k].
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   i        in   serial data bit
//   i_valid  in   qualifies i and sof
//   sof      in   start of frame (marks frame bit 0)
//   O        out  [7:0] last completed word, registered
//   o_valid  out  one-cycle pulse when O has just been updated
//   S        out  [2:0] index of the next bit to be written
//   busy     out  high while a frame is partially received
//   err      out  sticky frame error (sof seen mid-frame), cleared by rst
module serial_demux_1to8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i,
    input  logic       i_valid,
    input  logic       sof,
    output logic [7:0] O,
    output logic       o_valid,
    output logic [2:0] S,
    output logic       busy,
    output logic       err
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t     state, state_n;
    logic [7:0] asm_buf, asm_buf_n;
    logic [7:0] o_n;
    logic [2:0] s_n;
    logic       o_valid_n;
    logic       err_n;
    logic [7:0] wr_word;

    // Assembly buffer with the incoming bit placed at the current index.
    // On completion this is the finished word, bit 7 included.
    always_comb begin
        wr_word    = asm_buf;
        wr_word[S] = i;
    end

    always_comb begin
        state_n   = state;
        asm_buf_n = asm_buf;
        o_n       = O;
        s_n       = S;
        o_valid_n = 1'b0;
        err_n     = err;
        if (i_valid) begin
            case (state)
                IDLE: begin
                    // Bits without sof outside a frame are dropped.
                    if (sof) begin
                        asm_buf_n = {7'b0, i};
                        s_n       = 3'd1;
                        state_n   = RECV;
                    end
                end
                RECV: begin
                    if (sof) begin
                        // Restart: the partial frame is thrown away and
                        // this bit becomes bit 0 of a new frame.
                        err_n     = 1'b1;
                        asm_buf_n = {7'b0, i};
                        s_n       = 3'd1;
                    end else if (S == 3'd7) begin
                        asm_buf_n = wr_word;
                        o_n       = wr_word;
                        s_n       = 3'd0;
                        o_valid_n = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        asm_buf_n = wr_word;
                        s_n       = S + 3'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            asm_buf <= 8'h00;
            O       <= 8'h00;
            S       <= 3'd0;
            o_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            asm_buf <= asm_buf_n;
            O       <= o_n;
            S       <= s_n;
            o_valid <= o_valid_n;
            err     <= err_n;
        end
    end

    assign busy = (state == RECV);

endmodule

// File: tb/tb_serial_demux_1to8.sv
// Directed bench for serial_demux_1to8. Inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising edge.
module tb_serial_demux_1to8;

    logic       clk;
    logic       rst;
    logic       i;
    logic       i_valid;
    logic       sof;
    logic [7:0] O;
    logic       o_valid;
    logic [2:0] S;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    serial_demux_1to8 dut (
        .clk     (clk),
        .rst     (rst),
        .i       (i),
        .i_valid (i_valid),
        .sof     (sof),
        .O       (O),
        .o_valid (o_valid),
        .S       (S),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns just after the edge.
    task automatic step(input logic r, input logic v, input logic s, input logic b);
        @(negedge clk);
        rst     = r;
        i_valid = v;
        sof     = s;
        i       = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".O"},       O,             8'h00);
        chk({tag, ".o_valid"}, 8'(o_valid),   8'd0);
        chk({tag, ".S"},       8'(S),         8'd0);
        chk({tag, ".busy"},    8'(busy),      8'd0);
        chk({tag, ".err"},     8'(err),       8'd0);
    endtask

    // Sends one frame LSB first with sof on bit 0. 'gap' idle cycles are
    // inserted between bits; during gaps sof is held high with i_valid low,
    // which must be ignored.
    task automatic send_frame(input logic [7:0] w, input int gap, input logic [7:0] prev_o);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, (k == 0), w[k]);
            if (k < 7) begin
                chk($sformatf("f%0h.b%0d.S", w, k),       8'(S),       8'(k + 1));
                chk($sformatf("f%0h.b%0d.busy", w, k),    8'(busy),    8'd1);
                chk($sformatf("f%0h.b%0d.o_valid", w, k), 8'(o_valid), 8'd0);
                chk($sformatf("f%0h.b%0d.O", w, k),       O,           prev_o);
                for (int g = 0; g < gap; g++) begin
                    step(1'b0, 1'b0, 1'b1, ~w[k]);
                    chk($sformatf("f%0h.g%0d.S", w, k),       8'(S),       8'(k + 1));
                    chk($sformatf("f%0h.g%0d.busy", w, k),    8'(busy),    8'd1);
                    chk($sformatf("f%0h.g%0d.o_valid", w, k), 8'(o_valid), 8'd0);
                end
            end else begin
                chk($sformatf("f%0h.done.O", w),       O,           w);
                chk($sformatf("f%0h.done.o_valid", w), 8'(o_valid), 8'd1);
                chk($sformatf("f%0h.done.S", w),       8'(S),       8'd0);
                chk($sformatf("f%0h.done.busy", w),    8'(busy),    8'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; i = 1'b0; i_valid = 1'b0; sof = 1'b0;

        // Reset
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_reset_vals("reset");

        // A5 on consecutive cycles
        send_frame(8'hA5, 0, 8'h00);
        chk("a5.err", 8'(err), 8'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("a5.pulse_end", 8'(o_valid), 8'd0);
        chk("a5.hold_O",    O,           8'hA5);

        // 3C with two idle cycles between bits
        send_frame(8'h3C, 2, 8'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("3c.pulse_end", 8'(o_valid), 8'd0);
        chk("3c.hold_O",    O,           8'h3C);
        chk("3c.err",       8'(err),     8'd0);

        // Valid bits without sof while idle are ignored
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b0, k[0]);
            chk($sformatf("idle%0d.S", k),       8'(S),       8'd0);
            chk($sformatf("idle%0d.busy", k),    8'(busy),    8'd0);
            chk($sformatf("idle%0d.O", k),       O,           8'h3C);
            chk($sformatf("idle%0d.o_valid", k), 8'(o_valid), 8'd0);
        end

        // Five bits of a frame, then sof restarts with 0F
        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("part.S",    8'(S),    8'd5);
        chk("part.busy", 8'(busy), 8'd1);
        chk("part.err",  8'(err),  8'd0);
        send_frame(8'h0F, 0, 8'h3C);
        chk("0f.err", 8'(err), 8'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("0f.pulse_end",  8'(o_valid), 8'd0);
        chk("0f.err_sticky", 8'(err),     8'd1);

        // Reset clears err
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_reset_vals("reset2");

        // Back-to-back FF then 01, no gap
        send_frame(8'hFF, 0, 8'h00);
        send_frame(8'h01, 0, 8'hFF);
        chk("b2b.err", 8'(err), 8'd0);

        // Reset after 4 bits, with sof/i_valid also asserted (rst wins)
        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("mid.S", 8'(S), 8'd4);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk_reset_vals("midrst");
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst.no_pulse", 8'(o_valid), 8'd0);
        send_frame(8'h81, 0, 8'h00);
        chk("81.err", 8'(err), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_demux_1to8.md
SERIAL_DEMUX_1TO8 -- requirements
Module: serial_demux_1to8

Interface
REQ-001 Parameters: none; word width fixed at 8 bits, index width fixed at 3 bits.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 i  input  1  serial data bit.
REQ-006 i_valid  input  1  qualifies i; the bit is sampled on a rising edge of clk with i_valid=1.
REQ-007 sof  input  1  start-of-frame; qualified by i_valid; marks the bit as frame bit 0.
REQ-008 O  output  8  last completed word, registered; frame bit k appears at O[k] (LSB first; inverse of 8:1 select, S=k maps to I[k]).
REQ-009 o_valid  output  1  one-cycle pulse: O has just been updated.
REQ-010 S  output  3  index of the next bit to be written, registered.
REQ-011 busy  output  1  high while a frame is partially received.
REQ-012 err  output  1  sticky frame error; cleared only by rst.

Function
REQ-013 The block SHALL implement two states, IDLE and RECV, plus an internal 8-bit assembly buffer buf.
REQ-014 IDLE: when i_valid=1 and sof=0, the block SHALL ignore the bit and leave all state unchanged.
REQ-015 IDLE: when i_valid=1 and sof=1, the block SHALL write i to buf[0], set S=1, and go to RECV.
REQ-016 RECV: when i_valid=1, sof=0 and S<7, the block SHALL write i to buf[S] and increment S.
REQ-017 RECV: when i_valid=1, sof=0 and S=7, the block SHALL load O with buf carrying bit 7 = i, set S=0, go to IDLE, and assert o_valid for exactly the next cycle.
REQ-018 Latency: o_valid SHALL be high in the cycle immediately after the edge that samples bit 7; O SHALL be valid in that same cycle.
REQ-019 RECV: when i_valid=1 and sof=1, the block SHALL discard the partial frame, set err=1, write i to buf[0], set S=1, and stay in RECV.
REQ-020 With i_valid=0, the block SHALL hold state, S, buf and O; gaps of any length are legal mid-frame.
REQ-021 O SHALL change only on frame completion and SHALL hold its value otherwise.
REQ-022 busy SHALL equal (state==RECV).
REQ-023 sof with i_valid=0 SHALL have no effect.
REQ-024 Back-to-back frames are legal: bit 0 of the next frame may arrive in the cycle o_valid is high, and it SHALL be accepted per REQ-015.
REQ-025 S SHALL never wrap from 7 to 0 other than through completion (REQ-017) or reset.

Reset
REQ-026 On a rising edge of clk with rst=1, the block SHALL set the state to IDLE and set O=8'h00, o_valid=0, S=0, busy=0, err=0, buf=8'h00; rst SHALL override every other input in that cycle.
REQ-027 A reset mid-frame SHALL discard the partial frame with no o_valid pulse.

Verification
REQ-028 Bits for 8'hA5, LSB first, with sof on bit 0 on consecutive cycles -> the cycle after bit 7: O=8'hA5 and o_valid=1 for 1 cycle; S=0, busy=0, err=0.
REQ-029 Bits for 8'h3C with i_valid low for 2 cycles between every bit -> O=8'h3C once; S steps 1..7 only on valid bits; busy is high throughout.
REQ-030 Five valid bits 1, then sof with the frame 8'h0F -> err=1 (sticky); O=8'h0F; exactly one o_valid pulse.
REQ-031 Frames 8'hFF and 8'h01 back-to-back with no gap -> two o_valid pulses 8 cycles apart; O=8'hFF, then O=8'h01.
REQ-032 Valid bits with sof=0 while in IDLE -> no state change, S=0, busy=0, O unchanged.
REQ-033 rst asserted after 4 bits of a frame -> next cycle all outputs are at reset values; a subsequent frame 8'h81 yields O=8'h81.
